adder_seq_ctrl: RTL and testbench

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

---
 rtl/adder_seq_pkg.sv | 11 +
 rtl/adder_seq_ctrl_if.sv | 25 ++
 rtl/valid_delay.sv | 22 ++
 rtl/adder_seq_ctrl.sv | 83 ++++++++
 tb/tb_adder_seq_ctrl.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared state encoding, data widths and window geometry for adder_seq_ctrl
package adder_seq_pkg;
   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
   localparam int SUM_W = 20;
   localparam int PIX_W = 16;
   localparam int WIN   = 3;
   // a window centred behind (r,c) is incomplete until WIN-1 rows and columns have been seen
   function automatic logic is_border(input int r, input int c);
      return (r < WIN - 1) || (c < WIN - 1);
   endfunction
endpackage

// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if: pixel-stream input and window-sum control outputs of adder_seq_ctrl
interface adder_seq_ctrl_if #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
);
   logic                     pix_valid;
   logic                     pix_sof;
   logic                     win_en;
   logic                     sum_valid;
   logic                     sum_eol;
   logic                     sum_border;
   logic [$clog2(IMG_W)-1:0] col;
   logic [$clog2(IMG_H)-1:0] row;
   logic                     busy;
   logic                     frame_done;
   logic                     err_sof;
   modport master (
      output pix_valid, pix_sof,
      input  win_en, sum_valid, sum_eol, sum_border, col, row, busy, frame_done, err_sof
   );
   modport slave (
      input  pix_valid, pix_sof,
      output win_en, sum_valid, sum_eol, sum_border, col, row, busy, frame_done, err_sof
   );
endinterface

// File: rtl/valid_delay.sv
// valid_delay: DEPTH-stage tag shift register that tracks window slots through the adder pipeline
module valid_delay #(
   parameter int DEPTH = 2,
   parameter int W     = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] sr [DEPTH];
   // shift tags one stage per cycle; reset drops every slot in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end
   assign q = sr[DEPTH-1];
endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: frame/window sequencer for a pipelined 3x3 window adder; BORDER_PASS_EN also passes border windows
module adder_seq_ctrl
   import adder_seq_pkg::*;
#(
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int ADD_LAT = 2
) (
   input logic             clk,
   input logic             rst,
   adder_seq_ctrl_if.slave bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int FW = $clog2(ADD_LAT + 1) + 1;
   localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
   localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);
   state_t        state, state_nxt;
   logic [CW-1:0] col, col_nxt, pc;
   logic [RW-1:0] row, row_nxt, pr;
   logic [FW-1:0] fcnt;
   logic          acc, sof_acc, last, win, brd;
   logic          win_en, eol1, brd1, last1, err_sof;
   logic [3:0]    tag_q;
   // acceptance, pixel position (sof restarts at 0,0), window qualification and next state
   always_comb begin
      acc     = bus.pix_valid & ((state == ACTIVE) | bus.pix_sof);
      sof_acc = acc & bus.pix_sof;
      pc      = sof_acc ? '0 : col;
      pr      = sof_acc ? '0 : row;
      last    = acc & (pr == RMAX) & (pc == CMAX);
`ifdef BORDER_PASS_EN
      win     = acc;
      brd     = is_border(int'(pr), int'(pc));
`else
      win     = acc & ~is_border(int'(pr), int'(pc));
      brd     = 1'b0;
`endif
      col_nxt   = acc ? ((pc == CMAX) ? '0 : pc + 1'b1) : col;
      row_nxt   = acc ? ((pc == CMAX) ? ((pr == RMAX) ? '0 : pr + 1'b1) : pr) : row;
      state_nxt = acc ? (last ? FLUSH : ACTIVE)
                : ((state == FLUSH) && (fcnt == FW'(ADD_LAT))) ? IDLE : state;
   end
   // state, counters and the window register stage feeding the adder
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         col     <= '0;
         row     <= '0;
         fcnt    <= '0;
         win_en  <= 1'b0;
         eol1    <= 1'b0;
         brd1    <= 1'b0;
         last1   <= 1'b0;
         err_sof <= 1'b0;
      end else begin
         state   <= state_nxt;
         col     <= col_nxt;
         row     <= row_nxt;
         fcnt    <= (state == FLUSH) ? fcnt + 1'b1 : '0;
         win_en  <= win;
         eol1    <= win & (pc == CMAX);
         brd1    <= win & brd;
         last1   <= last;
         err_sof <= sof_acc & (state == ACTIVE);
      end
   end
   valid_delay #(.DEPTH(ADD_LAT), .W(4)) u_dly (
      .clk (clk),
      .rst (rst),
      .d   ({last1, brd1, eol1, win_en}),
      .q   (tag_q)
   );
   assign bus.win_en     = win_en;
   assign bus.sum_valid  = tag_q[0];
   assign bus.sum_eol    = tag_q[1];
   assign bus.sum_border = tag_q[2];
   assign bus.frame_done = tag_q[3];
   assign bus.err_sof    = err_sof;
   assign bus.col        = col;
   assign bus.row        = row;
   assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: scoreboard bench for adder_seq_ctrl with a frame-position reference model
module tb_adder_seq_ctrl;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int L  = 2;
   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);
   typedef struct {int cyc; bit eol; bit brd;} evt_t;
   typedef evt_t evt_q_t[$];
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   adder_seq_ctrl_if #(.IMG_W(W), .IMG_H(H)) bus ();
   adder_seq_ctrl #(.IMG_W(W), .IMG_H(H), .ADD_LAT(L)) dut (.clk(clk), .rst(rst), .bus(bus));
   // expected events: 0 win_en, 1 sum_valid, 2 frame_done, 3 err_sof
   evt_q_t q [4];
   string  names [4] = '{"win_en", "sum_valid", "frame_done", "err_sof"};
   int cyc = 0, tests = 0, fails = 0;
   bit started = 0;
   bit active = 0;
   int nxt = 0, busy_until = -1;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic evt_q_t keep(input evt_q_t a, input int r);
      evt_q_t b;
      foreach (a[i]) if (a[i].cyc <= r) b.push_back(a[i]);
      return b;
   endfunction
   task automatic push(input int k, input int c, input bit e, input bit b);
      evt_t x;
      x.cyc = c; x.eol = e; x.brd = b;
      q[k].push_back(x);
   endtask
   // one input cycle: check position/busy, drive inputs, advance the frame model
   task automatic step(input bit v, input bit s, input bit r);
      int rr, cc;
      bit bsy;
      bsy = active || (cyc <= busy_until);
      tests++;
      if (bus.col !== CW'(nxt % W) || bus.row !== RW'(nxt / W) || bus.busy !== bsy) begin
         fails++;
         $display("FAIL counters cyc=%0d got col=%0d row=%0d busy=%0b want col=%0d row=%0d busy=%0b",
                  cyc, bus.col, bus.row, bus.busy, nxt % W, nxt / W, bsy);
      end
      rst = r; bus.pix_valid = v; bus.pix_sof = s;
      if (r) begin
         for (int k = 0; k < 4; k++) q[k] = keep(q[k], cyc);
         active = 0; nxt = 0; busy_until = -1;
      end else if (v && (s || active)) begin
         if (s && active) push(3, cyc + 1, 0, 0);
         if (s) nxt = 0;
         rr = nxt / W;
         cc = nxt % W;
`ifdef BORDER_PASS_EN
         push(0, cyc + 1, 0, 0);
         push(1, cyc + 1 + L, cc == W - 1, rr < 2 || cc < 2);
`else
         if (rr >= 2 && cc >= 2) begin
            push(0, cyc + 1, 0, 0);
            push(1, cyc + 1 + L, cc == W - 1, 0);
         end
`endif
         if (nxt == W * H - 1) begin
            push(2, cyc + 1 + L, 0, 0);
            busy_until = cyc + 1 + L;
            active = 0; nxt = 0;
         end else begin
            active = 1; nxt++;
         end
      end
      @(posedge clk); #1;
   endtask
   task automatic chk(input int k, input bit sig, input bit e, input bit b);
      evt_t x;
      while (q[k].size() > 0 && q[k][0].cyc < cyc) begin
         tests++; fails++;
         $display("FAIL %s missing at cyc=%0d: got 0 want 1 at cyc %0d", names[k], cyc, q[k][0].cyc);
         void'(q[k].pop_front());
      end
      if (sig) begin
         tests++;
         if (q[k].size() == 0 || q[k][0].cyc != cyc) begin
            fails++;
            $display("FAIL %s unexpected at cyc=%0d: got 1 want 0", names[k], cyc);
         end else begin
            x = q[k].pop_front();
            if (k == 1 && (x.eol !== e || x.brd !== b)) begin
               fails++;
               $display("FAIL sum_tags cyc=%0d got eol=%0b border=%0b want eol=%0b border=%0b",
                        cyc, e, b, x.eol, x.brd);
            end
         end
      end
   endtask
   // monitor: pops expected events whenever the DUT presents an output
   always @(negedge clk) if (started) begin
      chk(0, bus.win_en, 1'b0, 1'b0);
      chk(1, bus.sum_valid, bus.sum_eol, bus.sum_border);
      chk(2, bus.frame_done, 1'b0, 1'b0);
      chk(3, bus.err_sof, 1'b0, 1'b0);
      tests++;
      if (!bus.sum_valid && (bus.sum_eol || bus.sum_border)) begin
         fails++;
         $display("FAIL stray_tags cyc=%0d got eol=%0b border=%0b without sum_valid want 0",
                  cyc, bus.sum_eol, bus.sum_border);
      end
   end
   task automatic idle(input int n);
      repeat (n) step(0, 0, 0);
   endtask
   task automatic frame(input int gap_at, input int gap_len, input int sof_at);
      for (int i = 0; i < W * H; i++) begin
         if (i == gap_at) idle(gap_len);
         step(1, i == 0 || i == sof_at, 0);
      end
   endtask
   initial begin
      bus.pix_valid = 0;
      bus.pix_sof   = 0;
      repeat (2) @(posedge clk);
      #1;
      started = 1;
      step(0, 0, 1);
      repeat (5) step(1, 0, 0);
      frame(-1, 0, -1);
      idle(6);
      frame(5, 3, -1);
      idle(6);
      frame(-1, 0, 6);
      repeat (6) step(1, 0, 0);
      idle(6);
      frame(-1, 0, -1);
      step(0, 0, 1);
      idle(6);
      frame(-1, 0, -1);
      frame(-1, 0, -1);
      idle(6);
      repeat (3000) step($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
      idle(10);
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (q[k].size() != 0) begin
            fails++;
            $display("FAIL %s leftover: got %0d pending want 0", names[k], q[k].size());
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
